// File: rtl/act_mask_scheduler_pkg.sv
// Shared types and helpers for the sparse-activation issue scheduler.
// Optional build macro used by the top: ACT_SCHED_SKIP_ZERO_ACT_EN.
package act_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Select-index width for a block of bn elements.
  function automatic int mask_width(input int bn);
    return (bn > 1) ? $clog2(bn) : 1;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic pop_is_one(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/act_mask_scheduler_if.sv
// Block-input and issue-output handshake bundle of the scheduler.
interface act_mask_scheduler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_NUMBER = 16,
  parameter int CNT_WIDTH    = 16
);
  localparam int MASK_WIDTH = $clog2(BLOCK_NUMBER);

  logic                             in_valid;
  logic                             in_ready;
  logic [BLOCK_NUMBER-1:0]          in_bitmap;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] in_act_data;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [MASK_WIDTH-1:0]            out_mask;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] out_act_block;
  logic                             out_last;
  logic                             done;
  logic [CNT_WIDTH-1:0]             issue_count;

  // Producer / consumer side (testbench or surrounding pipeline).
  modport master (
    output in_valid, in_bitmap, in_act_data, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_act_block, out_last, done, issue_count
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_bitmap, in_act_data, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_act_block, out_last, done, issue_count
  );
endinterface

// File: rtl/act_mask_scheduler_lsb_enc.sv
// Combinational lowest-set-bit encoder with an any-bit-set flag.
module act_sched_lsb_enc #(
  parameter int BLOCK_NUMBER = 16,
  parameter int MASK_WIDTH   = 4
) (
  input  logic [BLOCK_NUMBER-1:0] vec,
  output logic [MASK_WIDTH-1:0]   idx,
  output logic                    any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = BLOCK_NUMBER - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = MASK_WIDTH'(i);
        any = 1'b1;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/act_mask_scheduler.sv
// Sparse-activation issue scheduler: walks the nonzero-weight bitmap of an
// accepted block lowest-first, one select index per handshake.
// Build option: ACT_SCHED_SKIP_ZERO_ACT_EN also drops positions whose
// activation element is zero.
module act_mask_scheduler
  import act_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_NUMBER = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  act_mask_scheduler_if.slave  bus
);

  localparam int MASK_WIDTH = mask_width(BLOCK_NUMBER);
  localparam int ACT_W      = BLOCK_NUMBER * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [BLOCK_NUMBER-1:0] rem_q, rem_d;
  logic [ACT_W-1:0]        act_q, act_d;
  logic                    last_q, last_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    new_win_q, new_win_d;
  logic [MASK_WIDTH-1:0]   mask_q, mask_d;
  logic                    out_last_q, out_last_d;
  logic                    init_q;

  logic [BLOCK_NUMBER-1:0] eff_bitmap;
  logic [MASK_WIDTH-1:0]   enc_idx;
  logic                    enc_any;
  logic                    hs_out;
  logic                    rem_one;
  logic                    in_ready_s;
  logic                    acc;

`ifdef ACT_SCHED_SKIP_ZERO_ACT_EN
  // Dual sparsity: a position issues only if both weight and activation are nonzero.
  always_comb begin
    eff_bitmap = '0;
    for (int i = 0; i < BLOCK_NUMBER; i++) begin
      eff_bitmap[i] = bus.in_bitmap[i] & (|bus.in_act_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end
`else
  // Weight sparsity only; activation values are not inspected.
  always_comb begin
    eff_bitmap = bus.in_bitmap;
  end
`endif

  // Handshake decode; a new block may enter while the last bit of the current one leaves.
  always_comb begin
    hs_out     = (state_q == ST_ISSUE) && bus.out_ready;
    rem_one    = pop_is_one(64'(rem_q));
    in_ready_s = init_q && ((state_q == ST_IDLE) || (hs_out && rem_one));
    acc        = bus.in_valid && in_ready_s;
  end

  // Next-state, remaining-bitmap, counter and window-tracking logic.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    act_d     = act_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    new_win_d = new_win_q;

    case (state_q)
      ST_ISSUE: begin
        if (hs_out) begin
          rem_d = rem_q & (rem_q - BLOCK_NUMBER'(1));
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (rem_one) begin
            state_d = ST_IDLE;
            if (last_q) begin
              done_d    = 1'b1;
              new_win_d = 1'b1;
            end else begin
              new_win_d = new_win_q;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept overrides the drained bitmap; the count restarts only for a new window.
    if (acc) begin
      if (new_win_d) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_d;
      end
      new_win_d = 1'b0;
      rem_d     = eff_bitmap;
      act_d     = bus.in_act_data;
      last_d    = bus.in_last;
      if (eff_bitmap != '0) begin
        state_d = ST_ISSUE;
      end else begin
        state_d = ST_IDLE;
        if (bus.in_last) begin
          done_d    = 1'b1;
          new_win_d = 1'b1;
        end else begin
          new_win_d = 1'b0;
        end
      end
    end else begin
      rem_d = rem_d;
    end
  end

  act_sched_lsb_enc #(
    .BLOCK_NUMBER (BLOCK_NUMBER),
    .MASK_WIDTH   (MASK_WIDTH)
  ) u_lsb_enc (
    .vec (rem_d),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Precompute the registered select index and final-issue flag for the next cycle.
  always_comb begin
    mask_d     = enc_any ? enc_idx : '0;
    out_last_d = last_d && pop_is_one(64'(rem_d));
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      act_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      new_win_q  <= 1'b1;
      mask_q     <= '0;
      out_last_q <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      act_q      <= act_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      new_win_q  <= new_win_d;
      mask_q     <= mask_d;
      out_last_q <= out_last_d;
      init_q     <= 1'b1;
    end
  end

  // Output mapping.
  always_comb begin
    bus.in_ready      = in_ready_s;
    bus.out_valid     = (state_q == ST_ISSUE);
    bus.out_mask      = mask_q;
    bus.out_act_block = act_q;
    bus.out_last      = out_last_q;
    bus.done          = done_q;
    bus.issue_count   = cnt_q;
  end

endmodule

// File: tb/tb_act_mask_scheduler.sv
// Directed self-checking bench for act_mask_scheduler.
module tb_act_mask_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  act_mask_scheduler_if #(.DATA_WIDTH(8), .BLOCK_NUMBER(16), .CNT_WIDTH(16)) bus ();

  act_mask_scheduler #(.DATA_WIDTH(8), .BLOCK_NUMBER(16), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ACT_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ACT_B = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [127:0] ACT_C = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
  localparam logic [127:0] ACT_Z = 128'hFFFFFFFFFFFFFFFFFFFFFFFF44000011;

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_bitmap   = 16'h0000;
    bus.in_act_data = '0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_mask", 128'(bus.out_mask), 128'd0);
    chk("rst_count", 128'(bus.issue_count), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

    // Test 1: 16'h8421, last
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h8421; bus.in_act_data = ACT_A; bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid0", 128'(bus.out_valid), 128'd1);
    chk("t1_mask0", 128'(bus.out_mask), 128'd0);
    chk("t1_last0", 128'(bus.out_last), 128'd0);
    chk("t1_act", bus.out_act_block, ACT_A);
    step();
    chk("t1_mask5", 128'(bus.out_mask), 128'd5);
    step();
    chk("t1_mask10", 128'(bus.out_mask), 128'd10);
    chk("t1_last10", 128'(bus.out_last), 128'd0);
    step();
    chk("t1_mask15", 128'(bus.out_mask), 128'd15);
    chk("t1_last15", 128'(bus.out_last), 128'd1);
    chk("t1_ready_final", 128'(bus.in_ready), 128'd1);
    step();
    chk("t1_valid_end", 128'(bus.out_valid), 128'd0);
    chk("t1_done", 128'(bus.done), 128'd1);
    chk("t1_count", 128'(bus.issue_count), 128'd4);
    step();
    chk("t1_done_pulse", 128'(bus.done), 128'd0);
    chk("t1_count_hold", 128'(bus.issue_count), 128'd4);

    // Test 2: empty block, last
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h0000; bus.in_act_data = ACT_B; bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t2_valid", 128'(bus.out_valid), 128'd0);
    chk("t2_done", 128'(bus.done), 128'd1);
    chk("t2_count", 128'(bus.issue_count), 128'd0);
    step();
    chk("t2_done_pulse", 128'(bus.done), 128'd0);
    chk("t2_valid_after", 128'(bus.out_valid), 128'd0);

    // Test 3: 16'h0006 with downstream stalled for 3 cycles
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h0006; bus.in_act_data = ACT_C; bus.in_last = 1'b1;
    step();
    chk("t3_count_clear", 128'(bus.issue_count), 128'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_valid", 128'(bus.out_valid), 128'd1);
      chk("t3_stall_mask", 128'(bus.out_mask), 128'd1);
      chk("t3_stall_act", bus.out_act_block, ACT_C);
      chk("t3_stall_in_ready", 128'(bus.in_ready), 128'd0);
      if (k < 2) step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("t3_in_ready_two_left", 128'(bus.in_ready), 128'd0);
    step();
    chk("t3_mask2", 128'(bus.out_mask), 128'd2);
    chk("t3_in_ready_last", 128'(bus.in_ready), 128'd1);
    step();
    chk("t3_done", 128'(bus.done), 128'd1);
    chk("t3_count", 128'(bus.issue_count), 128'd2);

    // Test 4: back-to-back 16'h0001 (not last) then 16'h0003 (last)
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h0001; bus.in_act_data = ACT_A; bus.in_last = 1'b0;
    step();
    chk("t4_b1_mask", 128'(bus.out_mask), 128'd0);
    chk("t4_b1_last", 128'(bus.out_last), 128'd0);
    bus.in_bitmap = 16'h0003; bus.in_act_data = ACT_B; bus.in_last = 1'b1;
    #1;
    chk("t4_b2b_ready", 128'(bus.in_ready), 128'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t4_b2_valid", 128'(bus.out_valid), 128'd1);
    chk("t4_b2_mask0", 128'(bus.out_mask), 128'd0);
    chk("t4_b2_act", bus.out_act_block, ACT_B);
    chk("t4_b2_count", 128'(bus.issue_count), 128'd1);
    chk("t4_no_done_a", 128'(bus.done), 128'd0);
    step();
    chk("t4_b2_mask1", 128'(bus.out_mask), 128'd1);
    chk("t4_b2_last", 128'(bus.out_last), 128'd1);
    chk("t4_no_done_b", 128'(bus.done), 128'd0);
    step();
    chk("t4_done", 128'(bus.done), 128'd1);
    chk("t4_count", 128'(bus.issue_count), 128'd3);
    step();
    chk("t4_done_once", 128'(bus.done), 128'd0);

    // Test 5: reset in the middle of 16'hFFFF
    bus.in_valid = 1'b1; bus.in_bitmap = 16'hFFFF; bus.in_act_data = ACT_C; bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t5_mask5", 128'(bus.out_mask), 128'd5);
    chk("t5_count5", 128'(bus.issue_count), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("t5_rst_mask", 128'(bus.out_mask), 128'd0);
    chk("t5_rst_act", bus.out_act_block, 128'd0);
    chk("t5_rst_last", 128'(bus.out_last), 128'd0);
    chk("t5_rst_count", 128'(bus.issue_count), 128'd0);
    chk("t5_rst_done", 128'(bus.done), 128'd0);
    chk("t5_rst_ready", 128'(bus.in_ready), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_ready_again", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h0010; bus.in_act_data = ACT_A; bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t5_mask4", 128'(bus.out_mask), 128'd4);
    chk("t5_valid", 128'(bus.out_valid), 128'd1);
    step();
    chk("t5_done", 128'(bus.done), 128'd1);
    chk("t5_count1", 128'(bus.issue_count), 128'd1);

    // Test 6: 16'h000F with activation elements 1 and 2 zero
    bus.in_valid = 1'b1; bus.in_bitmap = 16'h000F; bus.in_act_data = ACT_Z; bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t6_mask0", 128'(bus.out_mask), 128'd0);
`ifdef ACT_SCHED_SKIP_ZERO_ACT_EN
    step();
    chk("t6_mask3", 128'(bus.out_mask), 128'd3);
    chk("t6_last3", 128'(bus.out_last), 128'd1);
    step();
    chk("t6_done", 128'(bus.done), 128'd1);
    chk("t6_count", 128'(bus.issue_count), 128'd2);
`else
    step();
    chk("t6_mask1", 128'(bus.out_mask), 128'd1);
    step();
    chk("t6_mask2", 128'(bus.out_mask), 128'd2);
    step();
    chk("t6_mask3", 128'(bus.out_mask), 128'd3);
    chk("t6_last3", 128'(bus.out_last), 128'd1);
    step();
    chk("t6_done", 128'(bus.done), 128'd1);
    chk("t6_count", 128'(bus.issue_count), 128'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
